// File: rtl/stream_tag_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_tag_arbiter_pkg
// Brief    : Shared multi-stream FIFO definitions: tag/word width derivation
//            and the field layout of a tagged FIFO word.
// Revision : 1.0 - initial release
// ============================================================================
package stream_tag_arbiter_pkg;

    // Supported number of streams sharing one FIFO.
    localparam int C_FLUX_MIN = 2;
    localparam int C_FLUX_MAX = 16;

    // Bits needed to carry a stream index; at least one bit.
    function automatic int tag_width_f(input int flux);
        return (flux <= 2) ? 1 : $clog2(flux);
    endfunction

    // Full tagged word: tag above payload.
    function automatic int word_width_f(input int data_width, input int flux);
        return data_width + tag_width_f(flux);
    endfunction

    // The tag field starts right above the payload.
    function automatic int tag_lsb_f(input int data_width);
        return data_width;
    endfunction

endpackage : stream_tag_arbiter_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Searches upward from ptr,
//            modulo N, and returns the first set request as one-hot grant
//            plus binary index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N         = 2,
    parameter int IDX_WIDTH = 1
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_any
);

    // One spare bit so ptr + offset cannot overflow before the modulo fold.
    logic [IDX_WIDTH:0] w_sum;

    // Walk the N candidates starting at ptr; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_sum     = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, ptr} + (IDX_WIDTH+1)'(i);
            if (w_sum >= (IDX_WIDTH+1)'(N)) begin
                w_sum = w_sum - (IDX_WIDTH+1)'(N);
            end
            if (!grant_any && req[w_sum[IDX_WIDTH-1:0]]) begin
                grant[w_sum[IDX_WIDTH-1:0]] = 1'b1;
                grant_idx                   = w_sum[IDX_WIDTH-1:0];
                grant_any                   = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/stream_tag_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_tag_arbiter
// Brief    : Round-robin arbiter merging FLUX valid/ready streams into one
//            tagged write port of a multi-stream FIFO, with per-stream
//            accepted-word counters.
// Revision : 1.0 - initial release
// ============================================================================
module stream_tag_arbiter
    import stream_tag_arbiter_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  FLUX       = 2,
    parameter int  CNT_WIDTH  = 16,
    localparam int TAG_WIDTH  = tag_width_f(FLUX),
    localparam int WIDTH      = word_width_f(DATA_WIDTH, FLUX)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLUX-1:0]            in_valid,
    input  logic [FLUX*DATA_WIDTH-1:0] in_data,
    output logic [FLUX-1:0]            in_ready,
    input  logic [FLUX-1:0]            fifo_full,
    output logic                       fifo_write,
    output logic [WIDTH-1:0]           fifo_din,
    output logic [FLUX*CNT_WIDTH-1:0]  xfer_cnt
);

    localparam int C_TAG_LSB = tag_lsb_f(DATA_WIDTH);

    logic                  r_fifo_write;
    logic [WIDTH-1:0]      r_fifo_din;
    logic [TAG_WIDTH-1:0]  r_ptr;

    logic [FLUX-1:0]       w_elig;
    logic [FLUX-1:0]       w_grant;
    logic [TAG_WIDTH-1:0]  w_grant_idx;
    logic                  w_grant_any;
    logic                  w_xfer;
    logic [TAG_WIDTH-1:0]  w_last_tag;
    logic [TAG_WIDTH-1:0]  w_ptr_next;
    logic [DATA_WIDTH-1:0] w_payload;

    assign w_last_tag = r_fifo_din[C_TAG_LSB +: TAG_WIDTH];

    // The full flag lags a write by one cycle, so the stream whose word is
    // being written right now must be treated as full this cycle.
    generate
        for (genvar f = 0; f < FLUX; f++) begin : g_elig
            assign w_elig[f] = in_valid[f] & ~fifo_full[f] &
                               ~(r_fifo_write & (w_last_tag == TAG_WIDTH'(f)));
        end
    endgenerate

    rr_pick #(
        .N         (FLUX),
        .IDX_WIDTH (TAG_WIDTH)
    ) u_rr_pick (
        .req       (w_elig),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    assign in_ready = rst ? '0 : w_grant;
    // Grants only go to valid streams, so any grant outside reset is a handshake.
    assign w_xfer   = w_grant_any & ~rst;

    assign w_ptr_next = (w_grant_idx == TAG_WIDTH'(FLUX-1)) ? '0
                                                            : w_grant_idx + 1'b1;

    // Mux the granted stream's payload (one-hot select, no dynamic slicing).
    always_comb begin
        w_payload = '0;
        for (int f = 0; f < FLUX; f++) begin
            if (w_grant[f]) begin
                w_payload = in_data[f*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output register: strobe every handshake, keep the last word otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_write <= 1'b0;
            r_fifo_din   <= '0;
        end else begin
            r_fifo_write <= w_xfer;
            if (w_xfer) begin
                r_fifo_din <= {w_grant_idx, w_payload};
            end
        end
    end

    // Round-robin pointer moves just past the stream that was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_next;
        end
    end

    generate
        for (genvar f = 0; f < FLUX; f++) begin : g_cnt
            logic [CNT_WIDTH-1:0] r_cnt;

            // Per-stream accepted-word counter, wraps naturally.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_xfer && w_grant[f]) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign xfer_cnt[f*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
        end
    endgenerate

    // A registered word still pending when reset hits never reaches the FIFO.
    assign fifo_write = r_fifo_write & ~rst;
    assign fifo_din   = r_fifo_din;

endmodule : stream_tag_arbiter
`default_nettype wire

// File: doc/stream_tag_arbiter.md
STREAM_TAG_ARBITER -- requirements
Module: stream_tag_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload width per input stream.
REQ-002 Parameter FLUX, default 2, legal range 2..16: number of input streams and tag values.
REQ-003 Parameter CNT_WIDTH, default 16: width of each per-stream transfer counter.
REQ-004 Derived constants: TAG_WIDTH = clog2(FLUX); WIDTH = DATA_WIDTH + TAG_WIDTH.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  FLUX  per-stream valid; bit f belongs to stream f.
REQ-008 in_data  input  FLUX*DATA_WIDTH  flattened payloads; stream f occupies bits [f*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_ready  output  FLUX  per-stream ready; at most one bit high per cycle.
REQ-010 fifo_full  input  FLUX  per-flux full flags from the downstream multi-stream FIFO.
REQ-011 fifo_write  output  1  write strobe to the downstream FIFO.
REQ-012 fifo_din  output  WIDTH  tagged word: tag in bits [WIDTH-1 -: TAG_WIDTH], payload in bits [DATA_WIDTH-1:0].
REQ-013 xfer_cnt  output  FLUX*CNT_WIDTH  per-stream accepted-word counters, stream f at [f*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-014 Stream f is eligible in a cycle iff in_valid[f]=1, fifo_full[f]=0, and NOT (fifo_write=1 and the fifo_din tag = f).
REQ-015 The eligibility exclusion of REQ-014 compensates for the one-cycle lag between a FIFO write and its full flag; it is mandatory.
REQ-016 Grant is round-robin: search starts at stream ptr, ascends modulo FLUX, and selects the first eligible stream.
REQ-017 in_ready[g]=1 combinationally for the granted stream g only; all other bits are 0; no eligible stream gives in_ready=0.
REQ-018 A transfer on stream g occurs when in_valid[g] and in_ready[g] are both 1.
REQ-019 On a transfer, the next edge loads fifo_write=1 and fifo_din={g, payload of g}; otherwise the next edge loads fifo_write=0 and fifo_din holds its previous value.
REQ-020 Latency is exactly one cycle from handshake to fifo_write; at most one word per cycle is sustained.
REQ-021 On a transfer from g, ptr becomes (g+1) mod FLUX; with no transfer, ptr holds.
REQ-022 On a transfer from g, xfer_cnt[g] increments by 1, wrapping from 2^CNT_WIDTH-1 to 0; the other counters hold.
REQ-023 A single active stream is granted at most every other cycle (REQ-014); two or more active streams with free FIFO slots sustain one write per cycle.
REQ-024 fifo_full[f] rising while stream f is valid blocks grant to f in that same cycle; words already registered are still written.
REQ-025 in_data of unselected streams has no effect; in_valid may deassert without a handshake (no protocol check).

Reset
REQ-026 With rst=1 at an edge: fifo_write=0, fifo_din=0, ptr=0, all xfer_cnt=0.
REQ-027 in_ready is forced to all-zero whenever rst=1, regardless of inputs.
REQ-028 A word registered but not yet written when reset asserts is discarded.

Structure
REQ-029 TAG_WIDTH/WIDTH derivation and the tagged-word field positions go in the shared FIFO package used by the multi-stream FIFO.
REQ-030 A combinational sub-module rr_pick (request vector, pointer in; one-hot grant and binary index out) implements REQ-016.
REQ-031 Output register, pointer and counters are sequential logic in the top module.

Verification
REQ-032 Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, fifo_write=0, fifo_din=0, all counters 0.
REQ-033 FLUX=2, both valid, FIFO never full, 8 cycles -> tags alternate 0,1,0,1..., fifo_write=1 every cycle after the first, each counter reaches 4.
REQ-034 Only stream 1 valid, data 0xA5 -> fifo_din=0x1A5 with fifo_write=1 on every second cycle only.
REQ-035 fifo_full=2'b01 with both streams valid -> stream 0 never granted, only tag 1 is written; releasing full resumes round-robin at stream 0.
REQ-036 Counter wrap with CNT_WIDTH=4: 17 transfers on stream 0 -> xfer_cnt[0]=1.
REQ-037 rst asserted the cycle after a handshake -> no fifo_write for that word; ptr=0 afterwards.
